// File: rtl/mmr_irq_coalescer.sv
// ============================================================================
//  Module   : mmr_irq_coalescer
//  Purpose  : Coalesces masked MMR interrupt events into one level-sensitive
//             host interrupt, firing on an event-count threshold or a timeout
//             measured from the first event. Bypass mode mirrors the pending
//             status with one cycle of latency.
//  Options  : MMR_IRQ_STATS_EN - when defined, irq_assert_count counts irq
//             rising edges; otherwise it is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmr_irq_coalescer #(
    parameter int N           = 2,
    parameter int COUNT_WIDTH = 8,
    parameter int TIMER_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N*32-1:0]        isr,
    input  logic [N*32-1:0]        imr,
    input  logic [N*32-1:0]        isr_pulses,
    input  logic                   coal_enable,
    input  logic [COUNT_WIDTH-1:0] coal_count_thresh,
    input  logic [TIMER_WIDTH-1:0] coal_timeout,
    output logic                   irq,
    output logic                   irq_pending,
    output logic [COUNT_WIDTH-1:0] event_count,
    output logic [1:0]             state,
    output logic [31:0]            irq_assert_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ASSERT = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] c_CNT_MAX   = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] c_CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMER_WIDTH-1:0] c_TIMER_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic                   r_irq;
    logic                   r_irq_pending;
    logic                   r_evt_d;
    logic [COUNT_WIDTH-1:0] r_event_count;
    logic [TIMER_WIDTH-1:0] r_timer;

    logic                   w_pend;
    logic                   w_evt;
    logic                   w_quiet;
    logic                   w_timeout_on;
    logic                   w_thresh_le1;
    logic [COUNT_WIDTH:0]   w_count_sum;
    logic                   w_fire;
    logic [COUNT_WIDTH-1:0] w_count_inc;
    logic [TIMER_WIDTH-1:0] w_timer_dec;

    // Event/pending detection and the ARMED-state fire and count arithmetic.
    always_comb begin
        w_pend       = |(isr & imr);
        w_evt        = |(isr_pulses & imr);
        // The ISR lags its pulse by one cycle, so a just-seen event still
        // counts as activity until the ISR word has caught up.
        w_quiet      = !w_pend && !w_evt && !r_evt_d;
        w_timeout_on = (coal_timeout != '0);
        w_thresh_le1 = (coal_count_thresh <= c_CNT_ONE);
        // One bit wider so a saturated count plus a new event still compares high.
        w_count_sum  = {1'b0, r_event_count} + {{COUNT_WIDTH{1'b0}}, w_evt};
        w_fire       = (w_count_sum >= {1'b0, coal_count_thresh}) ||
                       (w_timeout_on && (r_timer == c_TIMER_ONE));
        w_count_inc  = (r_event_count == c_CNT_MAX) ? c_CNT_MAX : w_count_sum[COUNT_WIDTH-1:0];
        // Hold at zero if the timeout is enabled live while the timer is idle.
        w_timer_dec  = (r_timer != '0) ? (r_timer - c_TIMER_ONE) : r_timer;
    end

    // Coalescing FSM with registered irq, count, timer and status outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_irq         <= 1'b0;
            r_irq_pending <= 1'b0;
            r_evt_d       <= 1'b0;
            r_event_count <= '0;
            r_timer       <= '0;
        end else begin
            r_irq_pending <= w_pend;
            r_evt_d       <= w_evt;
            if (!coal_enable) begin
                r_state       <= ST_IDLE;
                r_irq         <= w_pend;
                r_event_count <= '0;
                r_timer       <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_irq <= 1'b0;
                        if (w_evt) begin
                            if (w_thresh_le1) begin
                                r_state <= ST_ASSERT;
                            end else begin
                                r_state       <= ST_ARMED;
                                r_event_count <= c_CNT_ONE;
                                r_timer       <= coal_timeout;
                            end
                        end
                    end
                    ST_ARMED: begin
                        r_irq         <= 1'b0;
                        r_event_count <= w_count_inc;
                        if (w_timeout_on) begin
                            r_timer <= w_timer_dec;
                        end
                        if (w_fire) begin
                            r_state <= ST_ASSERT;
                        end else if (w_quiet) begin
                            r_state       <= ST_IDLE;
                            r_event_count <= '0;
                            r_timer       <= '0;
                        end
                    end
                    ST_ASSERT: begin
                        if (w_quiet) begin
                            r_state       <= ST_IDLE;
                            r_irq         <= 1'b0;
                            r_event_count <= '0;
                            r_timer       <= '0;
                        end else begin
                            r_irq <= 1'b1;
                        end
                    end
                    default: begin
                        r_state       <= ST_IDLE;
                        r_irq         <= 1'b0;
                        r_event_count <= '0;
                        r_timer       <= '0;
                    end
                endcase
            end
        end
    end

`ifdef MMR_IRQ_STATS_EN
    logic        r_irq_q;
    logic [31:0] r_assert_count;

    // Count rising edges of the registered irq; wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_irq_q        <= 1'b0;
            r_assert_count <= 32'h0;
        end else begin
            r_irq_q <= r_irq;
            if (r_irq && !r_irq_q) begin
                r_assert_count <= r_assert_count + 32'h1;
            end
        end
    end

    assign irq_assert_count = r_assert_count;
`else
    assign irq_assert_count = 32'h0;
`endif

    assign irq         = r_irq;
    assign irq_pending = r_irq_pending;
    assign event_count = r_event_count;
    assign state       = r_state;

endmodule

`default_nettype wire
